// File: rtl/md_issue_queue_if.sv
// Request and HI/LO-unit handshake bundle for md_issue_queue.
// The slave modport is the queue itself; master is the pipeline/unit side.
interface md_issue_queue_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        req_ready;

    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        md_busy;

    modport master (
        output req_valid, req_op, req_rs, req_rt,
        input  req_ready,
        input  md_start, md_op, md_rs, md_rt,
        output md_busy
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt,
        output req_ready,
        output md_start, md_op, md_rs, md_rt,
        input  md_busy
    );
endinterface

// File: rtl/md_issue_queue.sv
// In-order issue queue in front of the HI/LO multiply/divide unit, with mfhi/mflo stall.
// Optional MD_QUEUE_BYPASS_EN: an accepted request issues in the same cycle when queue and unit are idle.
module md_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    md_issue_queue_if.slave              bus,
    input  logic                         mf_req,
    output logic                         mf_stall,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         op_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [2:0] OP_IDLE = 3'b111;

    // Handshake: a request is taken on a rising edge where req_valid & req_ready;
    // req_ready depends only on registered count. The unit side has no ready:
    // an issue happens in any cycle md_op != 111, and the head pops at that edge.

    logic [2:0]    op_mem [DEPTH];
    logic [31:0]   rs_mem [DEPTH];
    logic [31:0]   rt_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic take;
    logic legal;
    logic push;
    logic pop;
    logic bypass;

    assign bus.req_ready = (count < CW'(DEPTH));
    assign take          = bus.req_valid & bus.req_ready;
    assign legal         = ~(bus.req_op[2] & bus.req_op[1]);
    assign pop           = (count != '0) & ~bus.md_busy;

`ifdef MD_QUEUE_BYPASS_EN
    assign bypass = take & legal & (count == '0) & ~bus.md_busy;
`else
    assign bypass = 1'b0;
`endif

    assign push     = take & legal & ~bypass;
    assign mf_stall = mf_req & ((count != '0) | bus.md_busy);

    // mthi/mtlo (op[2] set) go out with start low; the unit latches them directly.
    always_comb begin
        bus.md_start = 1'b0;
        bus.md_op    = OP_IDLE;
        bus.md_rs    = '0;
        bus.md_rt    = '0;
        if (pop) begin
            bus.md_op    = op_mem[rd_ptr];
            bus.md_rs    = rs_mem[rd_ptr];
            bus.md_rt    = rt_mem[rd_ptr];
            bus.md_start = ~op_mem[rd_ptr][2];
        end else if (bypass) begin
            bus.md_op    = bus.req_op;
            bus.md_rs    = bus.req_rs;
            bus.md_rt    = bus.req_rt;
            bus.md_start = ~bus.req_op[2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            op_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
            if (take && !legal) op_err <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= bus.req_op;
            rs_mem[wr_ptr] <= bus.req_rs;
            rt_mem[wr_ptr] <= bus.req_rt;
        end
    end
endmodule

// File: tb/tb_md_issue_queue.sv
// Self-checking bench for md_issue_queue: per-scenario tasks plus an issue scoreboard.
module tb_md_issue_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int EW    = 67;

  logic          clk = 1'b0;
  logic          reset;
  logic          mf_req;
  logic          mf_stall;
  logic [CW-1:0] count;
  logic          op_err;
  logic          man_busy;
  bit            unit_en;
  int            unit_cnt;

  md_issue_queue_if bus();

  md_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .mf_req   (mf_req),
    .mf_stall (mf_stall),
    .count    (count),
    .op_err   (op_err)
  );

  // Unit model: busy 5 cycles after mult/multu start, 10 after div/divu.
  assign bus.md_busy = unit_en ? (unit_cnt != 0) : man_busy;

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int            gaps_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_issue_cyc = -1;
  bit            err_model = 1'b0;

  task automatic drive_req(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_rs    = '0;
    bus.req_rt    = '0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    gaps_q.delete();
    err_model      = 1'b0;
    unit_cnt       = 0;
    last_issue_cyc = -1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One clock cycle: monitor at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [EW-1:0] req_e;
    logic [EW-1:0] exp_e;
    int  size0;
    bit  take, legal, exp_issue, act_issue, start_seen;
    int  lat;
    start_seen = 1'b0;
    lat = 0;
    @(negedge clk);
    size0 = exp_q.size();
    checks++;
    if (count !== CW'(size0)) begin
      errors++; $display("FAIL count: got %0d expected %0d (cycle %0d)", count, size0, cyc);
    end
    checks++;
    if (bus.req_ready !== (size0 < DEPTH)) begin
      errors++; $display("FAIL req_ready: got %b expected %b", bus.req_ready, size0 < DEPTH);
    end
    checks++;
    if (mf_stall !== (mf_req & ((size0 != 0) | bus.md_busy))) begin
      errors++; $display("FAIL mf_stall: got %b expected %b", mf_stall, mf_req & ((size0 != 0) | bus.md_busy));
    end
    checks++;
    if (op_err !== err_model) begin
      errors++; $display("FAIL op_err: got %b expected %b", op_err, err_model);
    end
    take  = bus.req_valid && (size0 < DEPTH);
    legal = (bus.req_op[2:1] != 2'b11);
    req_e = {bus.req_op, bus.req_rs, bus.req_rt};
    exp_issue = !bus.md_busy && (size0 != 0);
`ifdef MD_QUEUE_BYPASS_EN
    exp_issue = exp_issue || (!bus.md_busy && take && legal);
`endif
    if (take && legal) exp_q.push_back(req_e);
    if (take && !legal) err_model = 1'b1;
    act_issue = (bus.md_op !== 3'b111);
    checks++;
    if (act_issue !== exp_issue) begin
      errors++; $display("FAIL issue_valid: got %b expected %b (md_op=%b)", act_issue, exp_issue, bus.md_op);
    end
    if (exp_issue) begin
      exp_e = exp_q.pop_front();
      checks++;
      if ({bus.md_op, bus.md_rs, bus.md_rt} !== exp_e) begin
        errors++; $display("FAIL issue_data: got op=%b rs=%h rt=%h expected op=%b rs=%h rt=%h",
                           bus.md_op, bus.md_rs, bus.md_rt, exp_e[66:64], exp_e[63:32], exp_e[31:0]);
      end
      checks++;
      if (bus.md_start !== !exp_e[66]) begin
        errors++; $display("FAIL md_start: got %b expected %b", bus.md_start, !exp_e[66]);
      end
      if (last_issue_cyc >= 0) gaps_q.push_back(cyc - last_issue_cyc);
      last_issue_cyc = cyc;
      start_seen = !exp_e[66];
      lat = exp_e[65] ? 10 : 5;
    end else begin
      checks++;
      if ({bus.md_start, bus.md_rs, bus.md_rt} !== 65'd0) begin
        errors++; $display("FAIL idle_outputs: got start=%b rs=%h rt=%h expected all zero",
                           bus.md_start, bus.md_rs, bus.md_rt);
      end
    end
    @(posedge clk);
    #1;
    if (start_seen) unit_cnt = lat;
    else if (unit_cnt > 0) unit_cnt--;
    cyc++;
  endtask

  task automatic test_reset();
    idle_req();
    reset = 1'b0; mf_req = 1'b1; man_busy = 1'b1; unit_en = 1'b0;
    clear_model();
    #3;
    checks++;
    if (count !== '0 || bus.req_ready !== 1'b1 || op_err !== 1'b0) begin
      errors++; $display("FAIL reset_state: got count=%0d ready=%b op_err=%b expected 0/1/0", count, bus.req_ready, op_err);
    end
    checks++;
    if (bus.md_start !== 1'b0 || bus.md_op !== 3'b111 || bus.md_rs !== '0 || bus.md_rt !== '0) begin
      errors++; $display("FAIL reset_issue: got start=%b op=%b rs=%h rt=%h expected 0/111/0/0",
                         bus.md_start, bus.md_op, bus.md_rs, bus.md_rt);
    end
    checks++;
    if (mf_stall !== 1'b1) begin
      errors++; $display("FAIL reset_mf_stall_busy: got %b expected 1", mf_stall);
    end
    man_busy = 1'b0;
    #1;
    checks++;
    if (mf_stall !== 1'b0) begin
      errors++; $display("FAIL reset_mf_stall_idle: got %b expected 0", mf_stall);
    end
    mf_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_mult();
    drive_req(3'b000, 32'd3, 32'hFFFF_FFFC);
    step();
    idle_req();
    #1;
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_op !== 3'b000 || bus.md_rs !== 32'd3 || bus.md_rt !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL single_mult: got start=%b op=%b rs=%h rt=%h expected 1/000/00000003/fffffffc",
                         bus.md_start, bus.md_op, bus.md_rs, bus.md_rt);
    end
    step();
    checks++;
    if (count !== '0 || bus.md_op !== 3'b111) begin
      errors++; $display("FAIL single_mult_drain: got count=%0d op=%b expected 0/111", count, bus.md_op);
    end
  endtask

  task automatic test_full();
    man_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(3'b000, 32'(10 + i), 32'(20 + i));
      step();
    end
    checks++;
    if (count !== CW'(DEPTH) || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL full: got count=%0d ready=%b expected %0d/0", count, bus.req_ready, DEPTH);
    end
    drive_req(3'b001, 32'd99, 32'd99);
    step();
    checks++;
    if (count !== CW'(DEPTH)) begin
      errors++; $display("FAIL full_reject: got count=%0d expected %0d", count, DEPTH);
    end
    idle_req();
    man_busy = 1'b0;
    #1;
    checks++;
    if (bus.md_op !== 3'b000 || bus.md_rs !== 32'd10) begin
      errors++; $display("FAIL full_first_issue: got op=%b rs=%0d expected 000/10", bus.md_op, bus.md_rs);
    end
    repeat (DEPTH) step();
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL full_drain: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_mthi_mtlo();
    drive_req(3'b100, 32'h1234, 32'h0);
    step();
    drive_req(3'b101, 32'h0, 32'h5678);
    #1;
    checks++;
    if (bus.md_op !== 3'b100 || bus.md_rs !== 32'h1234 || bus.md_start !== 1'b0) begin
      errors++; $display("FAIL mthi: got op=%b rs=%h start=%b expected 100/1234/0", bus.md_op, bus.md_rs, bus.md_start);
    end
    step();
    idle_req();
    #1;
    checks++;
    if (bus.md_op !== 3'b101 || bus.md_rt !== 32'h5678 || bus.md_start !== 1'b0) begin
      errors++; $display("FAIL mtlo: got op=%b rt=%h start=%b expected 101/5678/0", bus.md_op, bus.md_rt, bus.md_start);
    end
    step();
    checks++;
    if (gaps_q.size() == 0 || gaps_q[gaps_q.size()-1] !== 1) begin
      errors++; $display("FAIL mthi_mtlo_gap: got %0d expected 1", gaps_q.size() ? gaps_q[gaps_q.size()-1] : -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops[4];
    int exp_gap[3];
    ops = '{3'b000, 3'b001, 3'b010, 3'b000};
    exp_gap = '{6, 6, 11};
    unit_en = 1'b1;
    gaps_q.delete();
    last_issue_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      drive_req(ops[i], 32'(100 + i), 32'(200 + i));
      step();
    end
    idle_req();
    for (int i = 0; i < 80 && gaps_q.size() < 3; i++) step();
    checks++;
    if (gaps_q.size() != 3) begin
      errors++; $display("FAIL b2b_timeout: got %0d gaps expected 3", gaps_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gaps_q[i] !== exp_gap[i]) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, gaps_q[i], exp_gap[i]);
        end
      end
    end
    repeat (12) step();
  endtask

  task automatic test_mf_stall();
    int stalled;
    stalled = 0;
    unit_en = 1'b1;
    drive_req(3'b011, 32'd50, 32'd7);
    mf_req = 1'b1;
    step();
    idle_req();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!mf_stall) break;
      stalled++;
      step();
    end
    checks++;
    if (stalled !== 11) begin
      errors++; $display("FAIL mf_stall_div: got %0d stall cycles expected 11", stalled);
    end
    checks++;
    if (count !== '0 || bus.md_busy !== 1'b0) begin
      errors++; $display("FAIL mf_stall_release: got count=%0d busy=%b expected 0/0", count, bus.md_busy);
    end
    mf_req = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    unit_en = 1'b0; man_busy = 1'b0;
    drive_req(3'b110, 32'd1, 32'd2);
    step();
    idle_req();
    #1;
    checks++;
    if (count !== '0 || op_err !== 1'b1) begin
      errors++; $display("FAIL illegal_op: got count=%0d op_err=%b expected 0/1", count, op_err);
    end
    drive_req(3'b111, 32'd3, 32'd4);
    step();
    idle_req();
    repeat (3) step();
    checks++;
    if (op_err !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky: got %b expected 1", op_err);
    end
    apply_reset();
    checks++;
    if (op_err !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: got %b expected 0", op_err);
    end
  endtask

  task automatic test_async_reset();
    unit_en = 1'b0; man_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(3'b000, 32'(30 + i), 32'(40 + i));
      step();
    end
    idle_req();
    checks++;
    if (count !== CW'(3)) begin
      errors++; $display("FAIL async_fill: got count=%0d expected 3", count);
    end
    #1;
    man_busy = 1'b0;
    #1;
    checks++;
    if (bus.md_op !== 3'b000 || bus.md_rs !== 32'd30) begin
      errors++; $display("FAIL async_pre_issue: got op=%b rs=%0d expected 000/30", bus.md_op, bus.md_rs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (count !== '0 || bus.md_op !== 3'b111 || bus.md_start !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got count=%0d op=%b start=%b ready=%b expected 0/111/0/1",
                         count, bus.md_op, bus.md_start, bus.req_ready);
    end
    clear_model();
    @(posedge clk); #1;
    reset = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 400; i++) begin
      unit_en = (i < 200);
      man_busy = ($urandom_range(0, 3) == 0);
      mf_req = $urandom_range(0, 1);
      if ($urandom_range(0, 2) != 0) begin
        op = 3'($urandom_range(0, 5));
        if ($urandom_range(0, 30) == 0) op = 3'b110;
        drive_req(op, $urandom, $urandom);
      end else begin
        idle_req();
      end
      step();
    end
    idle_req();
    man_busy = 1'b0;
    mf_req = 1'b0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || count != '0); i++) step();
    checks++;
    if (count !== '0 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got count=%0d pending=%0d expected 0/0", count, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_req();
    mf_req = 1'b0;
    man_busy = 1'b0;
    unit_en = 1'b0;
    unit_cnt = 0;
    test_reset();
    test_single_mult();
    test_full();
    test_mthi_mtlo();
    test_back_to_back();
    test_mf_stall();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_issue_queue.md
# md_issue_queue

Request queue and issue controller sitting directly upstream of the multiply/divide unit (HI/LO unit) in the E stage. It accepts mult/multu/div/divu/mthi/mtlo requests from the pipeline, buffers them in an in-order FIFO, and issues each to the unit only when the unit reports not busy. It also produces the stall for mfhi/mflo until all earlier HI/LO work has drained, so back-to-back multiply/divide instructions need not stall the pipeline.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- req_valid  in  1  pipeline presents a HI/LO request this cycle
- req_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 illegal
- req_rs  in  32  operand A / mthi data
- req_rt  in  32  operand B / mtlo data
- req_ready  out  1  queue can accept; a request is taken when req_valid & req_ready
- mf_req  in  1  mfhi/mflo in E stage wants HI/LO
- mf_stall  out  1  hold mfhi/mflo and everything behind it
- md_start  out  1  start strobe to HI/LO unit
- md_op  out  3  op to HI/LO unit; 111 when idle
- md_rs  out  32  operand A to unit
- md_rt  out  32  operand B to unit
- md_busy  in  1  HI/LO unit busy
- count  out  $clog2(DEPTH+1)  entries held
- op_err  out  1  sticky: an illegal op was presented

## Operation
- FIFO: write pointer, read pointer, count registers; pointers wrap modulo DEPTH.
- Enqueue: req_valid & req_ready & legal op -> store {op, rs, rt} at write pointer.
- Illegal op (110/111) with req_valid & req_ready: accepted, not stored, op_err set until reset.
- req_ready = (count < DEPTH); registered-state only, no pass-through when full even if a pop occurs that cycle.
- Issue (combinational from head): when count != 0 and md_busy == 0, drive md_op/md_rs/md_rt from head entry; md_start = 1 only for ops 000-011. Head is popped at the same edge.
- mthi/mtlo entries issue with md_start = 0; the unit writes HI from md_rs (mthi) or LO from md_rt (mtlo).
- When not issuing: md_start = 0, md_op = 111, md_rs = md_rt = 0. md_op must never be 100/101 except on the issue cycle.
- Unit raises busy on the edge that samples start, so the next head may issue the cycle after only if md_busy is low; no extra gap required.
- mf_stall = mf_req & (count != 0 | md_busy).
- Simultaneous enqueue and pop: count unchanged, both pointers advance.

## Timing
- Reset values: count 0, pointers 0, op_err 0, req_ready 1, md_start 0, md_op 111, md_rs/md_rt 0, mf_stall = mf_req & md_busy.
- Reset mid-operation clears queue immediately (asynchronous); pending entries lost; in-flight unit operation is the unit's concern.
- Enqueue at edge N -> earliest issue cycle N+1 (head valid) if md_busy = 0.
- mult/multu: next head issues 6 cycles after its own issue cycle (5 busy cycles); div/divu: 11.
- mthi/mtlo: consecutive entries issue on consecutive cycles.
- Order strictly preserved; no reordering of mthi/mtlo around pending mult/div.

## Configuration
- MD_QUEUE_BYPASS_EN defined: when count == 0, md_busy == 0 and a legal request is accepted, it is issued in the same cycle directly from req_* and not written to the FIFO (zero-latency issue). mf_stall unchanged.
- Not defined: every request is enqueued; minimum request-to-issue latency is one cycle.

## Test plan
- Reset, then mult rs=3 rt=-4 with md_busy low -> next cycle md_start=1, md_op=000, md_rs=3, md_rt=0xFFFFFFFC; count returns to 0.
- Four mult requests on consecutive cycles with DEPTH=4 and md_busy held high -> count=4, req_ready=0; fifth request not taken; release busy -> entries issue in order, one per not-busy cycle.
- mthi 0x1234 then mtlo 0x5678, unit idle -> md_op=100 with md_rs=0x1234, next cycle md_op=101 with md_rt=0x5678, md_start=0 both cycles.
- div pending plus mf_req=1 -> mf_stall=1 until count=0 and md_busy=0, then 0.
- req_op=110 -> not stored, count unchanged, op_err=1 until reset=0.
- reset driven low with count=3 between clock edges -> count=0, md_op=111 immediately, before next edge.
